// File: rtl/sr_using_t.sv
`default_nettype none
// ============================================================================
// Module   : sr_using_t (with leaf t_ff)
// Purpose  : N-bit set/reset register whose storage is built solely from
//            T flip-flops. Per-bit excitation logic turns each S/R request
//            into a toggle. S=R=1 holds the bit and is flagged as illegal.
// Ports    : clk          - rising-edge clock
//            rst          - synchronous active-high reset (highest priority)
//            en           - update enable; gates state change and detection
//            s, r         - per-bit set / reset requests
//            err_clr      - clears err_sticky and err_cnt
//            q, qb        - register state and its complement
//            illegal_bits - registered mask of bits with s=r=1 (en=1)
//            illegal      - registered OR of illegal_bits
//            err_sticky   - set by any illegal event, held until cleared
//            err_cnt      - saturating count of cycles with an illegal bit
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// t_ff : single T flip-flop, synchronous active-high reset.
// ----------------------------------------------------------------------------
module t_ff (
    input  logic t,
    input  logic clk,
    input  logic rst,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

    assign qb = ~q;

endmodule

// ----------------------------------------------------------------------------
// sr_using_t : top level
// ----------------------------------------------------------------------------
module sr_using_t #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] illegal_bits,
    output logic             illegal,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] w_toggle;
    logic [WIDTH-1:0] illegal_bits_d, illegal_bits_q;
    logic             illegal_d, illegal_q;
    logic             err_sticky_d, err_sticky_q;
    logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
    logic [CNT_W-1:0] w_cnt_base;

    // Storage: one T flip-flop per bit. A toggle is requested only when
    // the requested level differs from the current one, so S=R=1 holds.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bits
            assign w_toggle[i] = en & ((s[i] & ~r[i] & ~q[i]) |
                                       (r[i] & ~s[i] &  q[i]));
            t_ff u_t_ff (
                .t   (w_toggle[i]),
                .clk (clk),
                .rst (rst),
                .q   (q[i]),
                .qb  (qb[i])
            );
        end
    endgenerate

    // Error bookkeeping. A clear in the same cycle as an illegal event is
    // applied first, so the event is still recorded (cnt=1, sticky=1).
    always_comb begin
        illegal_bits_d = {WIDTH{en}} & s & r;
        illegal_d      = |illegal_bits_d;
        w_cnt_base     = err_clr ? '0 : err_cnt_q;
        err_cnt_d      = w_cnt_base;
        if (illegal_d && (w_cnt_base != c_CNT_MAX)) begin
            err_cnt_d = w_cnt_base + CNT_W'(1);
        end
        err_sticky_d   = (err_sticky_q & ~err_clr) | illegal_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_bits_q <= '0;
            illegal_q      <= 1'b0;
            err_sticky_q   <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            illegal_bits_q <= illegal_bits_d;
            illegal_q      <= illegal_d;
            err_sticky_q   <= err_sticky_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign illegal_bits = illegal_bits_q;
    assign illegal      = illegal_q;
    assign err_sticky   = err_sticky_q;
    assign err_cnt      = err_cnt_q;

endmodule

`default_nettype wire
